// File: rtl/compare_4bit.sv
// Registered unsigned magnitude comparator: emits a 2-bit A-vs-B relation code
// with a valid flag, one cycle after the operands are sampled.
module compare_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       o,
  output logic             out_valid
);

  localparam int unsigned CODE_W = 2;

  localparam logic [CODE_W-1:0] CODE_NONE = 2'b00;
  localparam logic [CODE_W-1:0] CODE_GT   = 2'b01;
  localparam logic [CODE_W-1:0] CODE_LT   = 2'b10;
  localparam logic [CODE_W-1:0] CODE_EQ   = 2'b11;

  logic              decided;
  logic              a_wins;
  logic [CODE_W-1:0] code_c;

  // Scan from the MSB down; the first differing bit fixes the relation.
  always_comb begin
    decided = 1'b0;
    a_wins  = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!decided && (a[i] != b[i])) begin
        decided = 1'b1;
        a_wins  = a[i];
      end
    end
    if (!decided) begin
      code_c = CODE_EQ;
    end else if (a_wins) begin
      code_c = CODE_GT;
    end else begin
      code_c = CODE_LT;
    end
  end

  // o holds across idle cycles so downstream can still read the last relation.
  always_ff @(posedge clk) begin
    if (rst) begin
      o         <= CODE_NONE;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      o         <= code_c;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_compare_4bit.sv
// Directed self-checking bench for compare_4bit at WIDTH=4 and WIDTH=8.
module tb_compare_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] o;
  logic       out_valid;

  logic       in_valid8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic [1:0] o8;
  logic       out_valid8;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  compare_4bit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .o(o), .out_valid(out_valid)
  );

  compare_4bit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .a(a8), .b(b8),
    .o(o8), .out_valid(out_valid8)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, let the rising edge sample, return at the next falling edge.
  task automatic apply(input logic r, input logic v, input logic [3:0] va, input logic [3:0] vb);
    rst = r; in_valid = v; a = va; b = vb;
    @(negedge clk);
  endtask

  task automatic apply8(input logic [7:0] va, input logic [7:0] vb);
    rst = 1'b0; in_valid = 1'b0; in_valid8 = 1'b1; a8 = va; b8 = vb;
    @(negedge clk);
  endtask

  task automatic expect4(input string tag, input logic [1:0] eo, input logic ev);
    check({tag, ".o"}, 8'(o), 8'(eo));
    check({tag, ".valid"}, 8'(out_valid), 8'(ev));
  endtask

  logic [3:0] bnd_a [7] = '{4'd0, 4'd15, 4'd15, 4'd0,  4'd8, 4'd7, 4'd6};
  logic [3:0] bnd_b [7] = '{4'd0, 4'd15, 4'd0,  4'd15, 4'd7, 4'd8, 4'd7};
  logic [1:0] bnd_o [7] = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10};

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 4'd5; b = 4'd3;
    in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0;

    // Reset held two cycles with a valid pair present.
    @(negedge clk);
    expect4("reset0", 2'b00, 1'b0);
    check("reset0.o8", 8'(o8), 8'd0);
    check("reset0.valid8", 8'(out_valid8), 8'd0);
    apply(1'b1, 1'b1, 4'd5, 4'd3);
    expect4("reset1", 2'b00, 1'b0);
    apply(1'b0, 1'b1, 4'd5, 4'd3);
    expect4("post_reset", 2'b01, 1'b1);

    // Exhaustive sweep, one pair per cycle.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        logic [1:0] ref_o;
        ref_o = (i > j) ? 2'b01 : (i < j) ? 2'b10 : 2'b11;
        apply(1'b0, 1'b1, 4'(i), 4'(j));
        expect4($sformatf("sweep_%0d_%0d", i, j), ref_o, 1'b1);
      end
    end

    // Boundary pairs back to back.
    for (int k = 0; k < 7; k++) begin
      apply(1'b0, 1'b1, bnd_a[k], bnd_b[k]);
      expect4($sformatf("bound_%0d_%0d", bnd_a[k], bnd_b[k]), bnd_o[k], 1'b1);
    end

    // Hold: idle cycles keep o and drop out_valid.
    apply(1'b0, 1'b1, 4'd9, 4'd4);
    expect4("hold_load", 2'b01, 1'b1);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 4'd1, 4'd2);
      expect4($sformatf("hold_%0d", k), 2'b01, 1'b0);
    end

    // Mid-stream reset.
    apply(1'b0, 1'b1, 4'd3, 4'd3);
    expect4("mid_eq", 2'b11, 1'b1);
    apply(1'b1, 1'b1, 4'd4, 4'd2);
    expect4("mid_rst", 2'b00, 1'b0);
    apply(1'b0, 1'b1, 4'd2, 4'd4);
    expect4("mid_after", 2'b10, 1'b1);

    // WIDTH=8 instance.
    apply8(8'd200, 8'd100);
    check("w8_200_100", 8'(o8), 8'(2'b01));
    check("w8_valid", 8'(out_valid8), 8'd1);
    check("w8_idle4", 8'(out_valid), 8'd0);
    apply8(8'd100, 8'd200);
    check("w8_100_200", 8'(o8), 8'(2'b10));
    apply8(8'd255, 8'd255);
    check("w8_255_255", 8'(o8), 8'(2'b11));
    apply8(8'd128, 8'd127);
    check("w8_128_127", 8'(o8), 8'(2'b01));
    in_valid8 = 1'b0;
    @(negedge clk);
    check("w8_hold_o", 8'(o8), 8'(2'b01));
    check("w8_hold_valid", 8'(out_valid8), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/compare_4bit.md
Name: compare_4bit

Overview:
- Registered unsigned magnitude comparator for two WIDTH-bit operands (default 4).
- Produces a 2-bit relation code: greater, lesser or equal.
- Sits in the datapath wherever a registered A-vs-B relation is needed, e.g. threshold checks and sort/select stages.
- Result is registered once; a valid flag accompanies it.

Parameters:
- WIDTH, 4, operand width in bits (legal range 1..32); both operands are unsigned.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a/b are valid this cycle
- a  input  WIDTH  operand A (unsigned)
- b  input  WIDTH  operand B (unsigned)
- o  output  2  relation code, registered
- out_valid  output  1  o holds a result computed from a valid input pair

Behaviour:
- Relation code encoding:
  - 2'b01 = a > b
  - 2'b10 = a < b
  - 2'b11 = a == b
  - 2'b00 = no result / invalid; never produced by a comparison.
- Comparison is unsigned and MSB-first: the first differing bit from the MSB down decides the result. If no bit differs, the operands are equal.
- Compare logic is combinational from a/b; o and out_valid are flops clocked on the rising edge of clk.
- Reset, synchronous, rst=1 at a rising edge: o <= 2'b00, out_valid <= 0. Reset overrides in_valid in the same cycle.
- Normal operation, rst=0 and in_valid=1 at an edge: o <= code(a,b), out_valid <= 1.
  - Latency is exactly 1 cycle: the result is visible after the edge that samples the operands.
  - Throughput is one comparison per cycle; back-to-back valid pairs are accepted with no bubbles.
- rst=0 and in_valid=0 at an edge: o holds its previous value and out_valid <= 0.
- Reset asserted mid-stream: the next edge clears o to 2'b00 and out_valid to 0. The first valid pair after reset deasserts produces a normal result one cycle later.
- o is never X after the first reset edge. Operand values while in_valid=0 are ignored.
- Boundary cases:
  - a=b=0 -> 11
  - a=b=max -> 11
  - a=max, b=0 -> 01
  - a=0, b=max -> 10
  - Operands differing only in the LSB -> decided by the LSB.
  - Operands differing only in the MSB -> decided by the MSB, regardless of the lower bits.
- No handshake back-pressure: the block is always ready.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=5, b=3 -> o=00 and out_valid=0 throughout; release rst -> the next edge gives o=01, out_valid=1.
- Exhaustive sweep: for all a,b in 0..15, drive in_valid=1 for one cycle each. After each edge o must match the reference: 01 if a>b, 10 if a<b, 11 if a==b. Code 00 must never appear and out_valid must be 1.
- Boundaries, back-to-back, one per cycle: (0,0)->11, (15,15)->11, (15,0)->01, (0,15)->10, (8,7)->01, (7,8)->10, (6,7)->10.
- Hold: valid pair (9,4) gives o=01; then in_valid=0 for 3 cycles while a/b change to (1,2) -> o stays 01 and out_valid=0.
- Mid-stream reset: stream (3,3),(4,2); assert rst on the cycle (4,2) is sampled -> o=00, out_valid=0; deassert and apply (2,4) -> o=10 one cycle later.
- Parameter check with WIDTH=8: (200,100)->01, (100,200)->10, (255,255)->11, (128,127)->01.
